dmem_arbiter: RTL and testbench

- Two-requester, round-robin arbiter that shares the single-port data memory (64 x 32-bit, combinational read, write on posedge clk) between port A (CPU data port) and port B (loader/debug master).
- Registers the grant, drives the memory port from the granted requester, and returns registered read data with a valid pulse.
- Checks address range and alignment; out-of-range or misaligned accesses never reach the memory.
- Sits directly between the requesters and dmem. dmem is unchanged.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data-memory port for dmem_arbiter.
// The slave view belongs to the arbiter; the master view belongs to requesters and dmem.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          a_req;
  logic          a_we;
  logic          a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_we;
  logic          b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  logic          mem_we;
  logic [31:0]   mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between port A (CPU) and port B
// (loader/debug). Registered grants, range/alignment filtering, registered responses.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);
  localparam int NP = 2;
  localparam logic [AW-3:0] DEPTH_W = DEPTH[AW-3:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;   // last served port: 0 = A, 1 = B
  logic [NP-1:0] gnt_q;

  logic [NP-1:0] req;
  logic [NP-1:0] we;
  logic [NP-1:0] lock;
  logic [NP-1:0] accept;
  logic [NP-1:0] legal;
  logic [AW-1:0] addr  [NP];
  logic [DW-1:0] wdata [NP];

  assign req      = {bus.b_req,  bus.a_req};
  assign we       = {bus.b_we,   bus.a_we};
  assign lock     = {bus.b_lock, bus.a_lock};
  assign addr[0]  = bus.a_addr;
  assign addr[1]  = bus.b_addr;
  assign wdata[0] = bus.a_wdata;
  assign wdata[1] = bus.b_wdata;

  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    logic          rvalid_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    assign legal[gi]  = (addr[gi][1:0] == 2'b00) && (addr[gi][AW-1:2] < DEPTH_W);
    assign accept[gi] = gnt_q[gi] & req[gi];

    // mem_rd is valid here because the accepted legal access is driving mem_a this cycle
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= accept[gi];
        if (accept[gi]) begin
          err_q   <= ~legal[gi];
          rdata_q <= (legal[gi] && !we[gi]) ? bus.mem_rd : '0;
        end else begin
          err_q   <= 1'b0;
        end
      end
    end
  end

  // Only one port can own the memory, so at most one accept bit is set
  always_comb begin
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    for (int i = 0; i < NP; i++) begin
      if (accept[i] && legal[i]) begin
        bus.mem_we = we[i] & reset_n;
        bus.mem_a  = 32'(addr[i]);
        bus.mem_wd = wdata[i];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept[0]) begin
      last_d = 1'b0;
    end else if (accept[1]) begin
      last_d = 1'b1;
    end

    state_d = IDLE;
    if (state_q == OWN_A && req[0] && lock[0]) begin
      state_d = OWN_A;
    end else if (state_q == OWN_B && req[1] && lock[1]) begin
      state_d = OWN_B;
    end else if (req[0] && req[1]) begin
      state_d = last_d ? OWN_A : OWN_B;
    end else if (req[0]) begin
      state_d = OWN_A;
    end else if (req[1]) begin
      state_d = OWN_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= {state_d == OWN_B, state_d == OWN_A};
    end
  end

  assign bus.a_gnt    = gnt_q[0];
  assign bus.b_gnt    = gnt_q[1];
  assign bus.a_rvalid = g_port[0].rvalid_q;
  assign bus.b_rvalid = g_port[1].rvalid_q;
  assign bus.a_err    = g_port[0].err_q;
  assign bus.b_err    = g_port[1].err_q;
  assign bus.a_rdata  = g_port[0].rdata_q;
  assign bus.b_rdata  = g_port[1].rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level reference of ownership, memory contents and responses.
module tb_dmem_arbiter;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Attached data memory: combinational read, write on posedge
  logic [31:0] dmem [DEPTH];
  assign bus.mem_rd = dmem[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) dmem[bus.mem_a[7:2]] <= bus.mem_wd;

  // Stimulus for the coming cycle
  logic        rst_v;
  logic        req_v   [2];
  logic        we_v    [2];
  logic        lock_v  [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  // Reference: owner (-1 none, 0 A, 1 B), last served, memory image, pending responses
  int          own;
  int          last_srv;
  logic [31:0] ref_mem [DEPTH];
  logic        exp_rv  [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];
  bit          acc_seen [2];
  bit          primed;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit          acc [2];
    bit          lg  [2];
    int          idx [2];
    logic        e_we;
    logic [31:0] e_a, e_wd;
    string       pn;

    @(negedge clk);
    if (primed) begin
      check("a_gnt",    bus.a_gnt,    32'(own == 0));
      check("b_gnt",    bus.b_gnt,    32'(own == 1));
      check("a_rvalid", bus.a_rvalid, exp_rv[0]);
      check("b_rvalid", bus.b_rvalid, exp_rv[1]);
      check("a_rdata",  bus.a_rdata,  exp_rd[0]);
      check("b_rdata",  bus.b_rdata,  exp_rd[1]);
      if (exp_rv[0]) check("a_err", bus.a_err, exp_err[0]);
      if (exp_rv[1]) check("b_err", bus.b_err, exp_err[1]);
      check("rv_excl", bus.a_rvalid & bus.b_rvalid, 0);
    end

    reset_n     = rst_v;
    bus.a_req   = req_v[0];   bus.b_req   = req_v[1];
    bus.a_we    = we_v[0];    bus.b_we    = we_v[1];
    bus.a_lock  = lock_v[0];  bus.b_lock  = lock_v[1];
    bus.a_addr  = addr_v[0];  bus.b_addr  = addr_v[1];
    bus.a_wdata = wdata_v[0]; bus.b_wdata = wdata_v[1];
    #1;

    e_we = 1'b0; e_a = '0; e_wd = '0;
    for (int p = 0; p < 2; p++) begin
      acc[p] = (own == p) && req_v[p];
      lg[p]  = (addr_v[p][1:0] == 2'b00) && ((addr_v[p] >> 2) < 32'(DEPTH));
      idx[p] = int'(addr_v[p][7:2]);
      if (acc[p] && lg[p]) begin
        e_a  = addr_v[p];
        e_wd = wdata_v[p];
        e_we = we_v[p] & rst_v;
      end
    end
    check("mem_we", bus.mem_we, e_we);
    if (rst_v) check("mem_a", bus.mem_a, e_a);
    if (e_we) check("mem_wd", bus.mem_wd, e_wd);

    if (!rst_v) begin
      own = -1;
      last_srv = 1;
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = '0; acc_seen[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        acc_seen[p] = acc[p];
        exp_rv[p]   = acc[p];
        if (acc[p]) begin
          exp_err[p] = ~lg[p];
          exp_rd[p]  = (lg[p] && !we_v[p]) ? ref_mem[idx[p]] : 32'h0;
          pn = (p == 0) ? "A" : "B";
          $display("t=%0t port %s %s addr=%h wdata=%h legal=%0d", $time, pn,
                   we_v[p] ? "WR" : "RD", addr_v[p], wdata_v[p], lg[p]);
        end
      end
      for (int p = 0; p < 2; p++)
        if (acc[p] && lg[p] && we_v[p]) ref_mem[idx[p]] = wdata_v[p];
      if (acc[0]) last_srv = 0;
      else if (acc[1]) last_srv = 1;

      if (own == 0 && req_v[0] && lock_v[0]) own = 0;
      else if (own == 1 && req_v[1] && lock_v[1]) own = 1;
      else if (req_v[0] && req_v[1]) own = 1 - last_srv;
      else if (req_v[0]) own = 0;
      else if (req_v[1]) own = 1;
      else own = -1;
    end
    primed = 1'b1;
  endtask

  task automatic do_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_v[p] = 1'b1; we_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
    do begin
      step();
      n++;
    end while (!acc_seen[p] && n < 10);
    check("acc_timeout", 32'(acc_seen[p]), 1);
    req_v[p] = 1'b0; we_v[p] = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ga, gb, rva, rvb, bacc, runb, n;
    logic [31:0] keep0, keep8;
    int          r;

    n_cmp = 0; n_bad = 0; primed = 1'b0;
    own = -1; last_srv = 1;
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    rst_v = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b1; we_v[p] = 1'b0; lock_v[p] = 1'b0;
      addr_v[p] = 32'(p * 4); wdata_v[p] = '0;
    end

    // Reset held with both requesting
    for (int k = 0; k < 3; k++) step();
    check("rst_a_gnt", bus.a_gnt, 0);
    check("rst_b_rvalid", bus.b_rvalid, 0);

    // Release into contention: expect A,B,A,B,A,B
    rst_v = 1'b1;
    ga = 0; gb = 0; rva = 0; rvb = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k >= 2 && k <= 7) begin ga += int'(bus.a_gnt); gb += int'(bus.b_gnt); end
      if (k >= 3 && k <= 8) begin rva += int'(bus.a_rvalid); rvb += int'(bus.b_rvalid); end
    end
    check("cont_gnt_a", ga, 3);
    check("cont_gnt_b", gb, 3);
    check("cont_rv_a", rva, 3);
    check("cont_rv_b", rvb, 3);
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    step(); step();

    // Single write then read on A
    do_access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("wr10_err", bus.a_err, 0);
    do_access(0, 1'b0, 32'h10, 32'h0);
    check("rd10_rvalid", bus.a_rvalid, 1);
    check("rd10_rdata", bus.a_rdata, 32'hDEADBEEF);

    // Illegal accesses: out of range write aliases word 0, misaligned read
    keep0 = dmem[0];
    do_access(0, 1'b1, 32'h100, 32'h55AA55AA);
    check("err_wr_err", bus.a_err, 1);
    check("err_wr_rdata", bus.a_rdata, 0);
    do_access(0, 1'b0, 32'h12, 32'h0);
    check("err_rd_err", bus.a_err, 1);
    check("err_rd_rdata", bus.a_rdata, 0);
    check("mem0_keep", dmem[0], keep0);

    // Lock on B for four accesses while A waits
    req_v[0] = 1'b1; addr_v[0] = 32'h4; we_v[0] = 1'b0;
    req_v[1] = 1'b1; addr_v[1] = 32'h8; we_v[1] = 1'b0; lock_v[1] = 1'b1;
    bacc = 0; runb = 0;
    for (int k = 0; k < 14 && bacc < 4; k++) begin
      if (bacc == 3) lock_v[1] = 1'b0;
      step();
      runb += int'(bus.b_gnt);
      if (acc_seen[1]) bacc++;
    end
    check("lock_run", runb, 4);
    req_v[1] = 1'b0;
    step();
    check("lock_handover", bus.a_gnt, 1);
    req_v[0] = 1'b0;
    step(); step();

    // Reset sampled at the edge where B's write would commit
    keep8 = dmem[8];
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; wdata_v[1] = 32'h12345678;
    n = 0;
    do begin
      step();
      n++;
    end while (own != 1 && n < 10);
    check("midrst_gnt_timeout", 32'(own == 1), 1);
    rst_v = 1'b0;
    step();
    rst_v = 1'b1; req_v[1] = 1'b0; we_v[1] = 1'b0;
    step();
    check("midrst_mem20", dmem[8], keep8);
    check("midrst_b_rvalid", bus.b_rvalid, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst_v = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++) begin
        req_v[p]   = ($urandom_range(0, 2) != 0);
        we_v[p]    = 1'($urandom_range(0, 1));
        lock_v[p]  = ($urandom_range(0, 3) == 0);
        wdata_v[p] = $urandom;
        r = int'($urandom_range(0, 15));
        if (r == 0) addr_v[p] = $urandom;
        else if (r == 1) addr_v[p] = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        else addr_v[p] = 32'($urandom_range(0, 63) * 4);
      end
      step();
    end
    rst_v = 1'b1; req_v[0] = 1'b0; req_v[1] = 1'b0;
    step(); step();

    for (int i = 0; i < DEPTH; i++) check("mem_final", dmem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
